// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit -- RV32I instruction-fetch stage.
//
// Owns the program counter, issues instruction-memory requests and presents
// the fetched instruction with its PC and PC+4 to decode. Commits either the
// execute-stage redirect target (c) or the sequential PC+4 each cycle, honours
// decode stalls and latches a sticky fault on misaligned redirect targets.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   jump_or_branch  redirect request from execute, target on c
//   c               redirect target address
//   stall           decode not accepting; hold the presented instruction
//   imem_req        fetch request (decoded from state, stall, inst_valid)
//   imem_addr       fetch address, always the PC register
//   imem_ready      memory completes the request this cycle
//   imem_rdata      fetched instruction word
//   inst, inst_pc, inst_pc4, inst_valid   instruction presented to decode
//   misalign_fault  sticky; a redirect target had c[1:0] != 0
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_or_branch,
  input  logic [31:0] c,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        inst_valid,
  output logic        misalign_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        redirect_ok;
  logic        redirect_bad;
  logic        hold;
  logic        fetch_done;

  assign pc_plus4  = pc_q + 32'd4;   // modulo 2^32, wraps without fault
  assign imem_addr = pc_q;

  // Request never depends on redirect/ready inputs, only on registered
  // state and the stall input gated by the held-instruction flag.
  assign imem_req = (state_q == RUN) && !(stall && inst_valid);

  assign redirect_ok  = (state_q == RUN) && jump_or_branch && (c[1:0] == 2'b00);
  assign redirect_bad = (state_q == RUN) && jump_or_branch && (c[1:0] != 2'b00);
  assign hold         = stall && inst_valid;
  assign fetch_done   = imem_req && imem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_bad) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      inst           <= NOP;
      inst_pc        <= RESET_PC;
      inst_pc4       <= RESET_PC + 32'd4;
      inst_valid     <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (redirect_ok) begin
            // Any fetch completing alongside the redirect is dropped.
            pc_q       <= c;
            inst_valid <= 1'b0;
          end else if (redirect_bad) begin
            misalign_fault <= 1'b1;
            inst_valid     <= 1'b0;
          end else if (hold) begin
            // Decode is stalled on a valid instruction: everything holds.
          end else if (fetch_done) begin
            inst       <= imem_rdata;
            inst_pc    <= pc_q;
            inst_pc4   <= pc_plus4;
            inst_valid <= 1'b1;
            pc_q       <= pc_plus4;
          end else begin
            inst_valid <= 1'b0;
          end
        end
        FAULT: begin
          inst_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit with RESET_PC = 0x100.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_or_branch;
  logic [31:0] c;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        inst_valid;
  logic        misalign_fault;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  // Memory word is a fixed scramble of the address so each fetch is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_or_branch (jump_or_branch),
    .c              (c),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4),
    .inst_valid     (inst_valid),
    .misalign_fault (misalign_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; jump_or_branch = 1'b0; c = '0; stall = 1'b0; imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req",      {31'd0, imem_req},       32'd0);
    check("rst_addr",     imem_addr,               32'h100);
    check("rst_inst",     inst,                    32'h13);
    check("rst_pc",       inst_pc,                 32'h100);
    check("rst_pc4",      inst_pc4,                32'h104);
    check("rst_valid",    {31'd0, inst_valid},     32'd0);
    check("rst_fault",    {31'd0, misalign_fault}, 32'd0);

    // Release just after an edge so a whole BOOT cycle is visible.
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("boot_req",     {31'd0, imem_req},       32'd0);
    @(negedge clk);
    check("f0_req",       {31'd0, imem_req},       32'd1);
    check("f0_addr",      imem_addr,               32'h100);
    check("f0_valid",     {31'd0, inst_valid},     32'd0);
    @(negedge clk);
    check("f1_addr",      imem_addr,               32'h104);
    check("f1_valid",     {31'd0, inst_valid},     32'd1);
    check("f1_pc",        inst_pc,                 32'h100);
    check("f1_pc4",       inst_pc4,                32'h104);
    check("f1_inst",      inst,                    mem_word(32'h100));
    @(negedge clk);
    check("f2_addr",      imem_addr,               32'h108);
    check("f2_pc",        inst_pc,                 32'h104);

    // Redirect to 0x4 while 0x108 is being fetched.
    jump_or_branch = 1'b1; c = 32'h4;
    @(negedge clk);
    jump_or_branch = 1'b0;
    check("rd_valid",     {31'd0, inst_valid},     32'd0);
    check("rd_addr",      imem_addr,               32'h4);
    @(negedge clk);
    check("rd_pc",        inst_pc,                 32'h4);
    check("rd_pc4",       inst_pc4,                32'h8);
    check("rd_inst",      inst,                    mem_word(32'h4));

    // Move to 0x10c and stall three cycles once it is valid.
    jump_or_branch = 1'b1; c = 32'h10c;
    @(negedge clk);
    jump_or_branch = 1'b0;
    @(negedge clk);
    check("st_pc0",       inst_pc,                 32'h10c);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_req",     {31'd0, imem_req},       32'd0);
      check("st_pc",      inst_pc,                 32'h10c);
      check("st_inst",    inst,                    mem_word(32'h10c));
      @(negedge clk);
    end
    check("st_valid",     {31'd0, inst_valid},     32'd1);
    check("st_pc_end",    inst_pc,                 32'h10c);
    stall = 1'b0;
    #1 check("st_rel_addr", imem_addr,             32'h110);
    @(negedge clk);
    check("st_next_pc",   inst_pc,                 32'h110);
    check("st_next_inst", inst,                    mem_word(32'h110));

    // Redirect and stall in the same cycle: redirect wins.
    stall = 1'b1; jump_or_branch = 1'b1; c = 32'h200;
    @(negedge clk);
    jump_or_branch = 1'b0;
    check("rs_valid",     {31'd0, inst_valid},     32'd0);
    check("rs_addr",      imem_addr,               32'h200);
    check("rs_req",       {31'd0, imem_req},       32'd1);
    @(negedge clk);
    check("rs_pc",        inst_pc,                 32'h200);
    check("rs_held_req",  {31'd0, imem_req},       32'd0);

    // Wait states at the top of the address space, then wrap.
    stall = 1'b0; jump_or_branch = 1'b1; c = 32'hFFFF_FFFC;
    @(negedge clk);
    jump_or_branch = 1'b0; imem_ready = 1'b0;
    check("ws_addr0",     imem_addr,               32'hFFFF_FFFC);
    @(negedge clk);
    check("ws_addr1",     imem_addr,               32'hFFFF_FFFC);
    check("ws_valid1",    {31'd0, inst_valid},     32'd0);
    @(negedge clk);
    check("ws_addr2",     imem_addr,               32'hFFFF_FFFC);
    check("ws_valid2",    {31'd0, inst_valid},     32'd0);
    imem_ready = 1'b1;
    @(negedge clk);
    check("wr_pc",        inst_pc,                 32'hFFFF_FFFC);
    check("wr_pc4",       inst_pc4,                32'h0);
    check("wr_addr",      imem_addr,               32'h0);
    check("wr_valid",     {31'd0, inst_valid},     32'd1);

    // Misaligned redirect from pc 0x0.
    jump_or_branch = 1'b1; c = 32'h6;
    @(negedge clk);
    check("mf_fault",     {31'd0, misalign_fault}, 32'd1);
    check("mf_req",       {31'd0, imem_req},       32'd0);
    check("mf_valid",     {31'd0, inst_valid},     32'd0);
    check("mf_addr",      imem_addr,               32'h0);
    // A later aligned redirect must not leave the fault state.
    c = 32'h40;
    repeat (2) @(negedge clk);
    jump_or_branch = 1'b0;
    check("mf_stuck",     {31'd0, misalign_fault}, 32'd1);
    check("mf_req2",      {31'd0, imem_req},       32'd0);
    check("mf_addr2",     imem_addr,               32'h0);

    // Asynchronous reset mid-cycle clears the fault.
    #2 rst_n = 1'b0;
    #1;
    check("ar_fault",     {31'd0, misalign_fault}, 32'd0);
    check("ar_addr",      imem_addr,               32'h100);
    check("ar_req",       {31'd0, imem_req},       32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ar_boot_req",  {31'd0, imem_req},       32'd0);
    @(negedge clk);
    check("ar_req1",      {31'd0, imem_req},       32'd1);
    check("ar_addr1",     imem_addr,               32'h100);
    @(negedge clk);
    check("ar_pc",        inst_pc,                 32'h100);
    check("ar_valid",     {31'd0, inst_valid},     32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
